// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ requesters.
// Latency: grant one edge after req is seen in IDLE, m_start on the next edge if the master is idle.
// Backpressure: m_busy holds the command in ISSUE; req changes are ignored until the FSM is back in IDLE.
module i2c_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic              err,
    output logic              m_start,
    output logic              m_rw,
    output logic [6:0]        m_addr,
    output logic [7:0]        m_wdata,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic              m_nack,
    input  logic [7:0]        m_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Counter is never narrower than 10 bits so the default TIMEOUT fits.
    localparam int CW = ($clog2(TIMEOUT) > 10) ? $clog2(TIMEOUT) : 10;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] last;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;

    logic          pick_vld;
    logic [IW-1:0] pick_idx;

    // Round-robin search starting at last+1; walking from lowest priority up
    // lets the final hit be the highest-priority requester.
    always_comb begin
        int            j;
        logic [IW-1:0] cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j    = (int'(last) + k) % NREQ;
            cand = IW'(j);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Transaction FSM: grant, issue the command, wait for the master, respond.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            last    <= IW'(NREQ - 1);
            idx     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
            rdata   <= 8'h00;
            err     <= 1'b0;
            m_start <= 1'b0;
            m_rw    <= 1'b0;
            m_addr  <= 7'h00;
            m_wdata <= 8'h00;
        end else begin
            m_start <= 1'b0;
            done    <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        idx     <= pick_idx;
                        gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        m_rw    <= req_rw[pick_idx];
                        m_addr  <= req_addr[pick_idx*7 +: 7];
                        m_wdata <= req_wdata[pick_idx*8 +: 8];
                        state   <= ISSUE;
                    end else begin
                        gnt <= '0;
                    end
                end
                ISSUE: begin
                    if (!m_busy) begin
                        m_start <= 1'b1;
                        cnt     <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // A completion arriving on the timeout cycle takes precedence.
                    if (m_done) begin
                        rdata <= m_rw ? 8'h00 : m_rdata;
                        err   <= m_nack;
                        state <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rdata <= 8'h00;
                        err   <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // RESP: done mirrors the one-hot grant; gnt drops on the next IDLE edge.
                    done  <= gnt;
                    last  <= idx;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: write, round-robin, read NACK, busy hold, timeout, reset abort.
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: m_busy is driven directly to exercise the ISSUE hold.
module tb_i2c_arbiter;

    localparam int T = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_rw;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  rdata;
    logic        err;
    logic        m_start;
    logic        m_rw;
    logic [6:0]  m_addr;
    logic [7:0]  m_wdata;
    logic        m_busy;
    logic        m_done;
    logic        m_nack;
    logic [7:0]  m_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int starts      = 0;
    int dones       = 0;

    i2c_arbiter #(.NREQ(4), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_start) starts <= starts + 1;
        if (done != 4'b0) dones <= dones + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int d0;
        int n;
        logic [3:0] eg;

        rst = 1'b0; req = 4'b0; req_rw = 4'b0; req_addr = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        steps(2);
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_done", done, 4'b0);
        chk("rst_mstart", m_start, 1'b0);
        chk("rst_mrw", m_rw, 1'b0);
        chk("rst_maddr", m_addr, 7'h00);
        chk("rst_mwdata", m_wdata, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_err", err, 1'b0);
        rst = 1'b1;
        step();

        // Single write from requester 1, dropped req before done
        req_rw[1] = 1'b1; req_addr[13:7] = 7'h77; req_wdata[15:8] = 8'hA5; req = 4'b0010;
        s0 = starts; d0 = dones;
        step();
        chk("w_gnt", gnt, 4'b0010);
        chk("w_nostart_yet", m_start, 1'b0);
        req = 4'b0;
        step();
        chk("w_start", m_start, 1'b1);
        chk("w_maddr", m_addr, 7'h77);
        chk("w_mwdata", m_wdata, 8'hA5);
        chk("w_mrw", m_rw, 1'b1);
        steps(39);
        m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'hFF;
        step();
        m_done = 1'b0; m_rdata = 8'h00;
        step();
        chk("w_done", done, 4'b0010);
        chk("w_err", err, 1'b0);
        chk("w_rdata", rdata, 8'h00);
        chk("w_maddr_hold", m_addr, 7'h77);
        step();
        chk("w_done_pulse", done, 4'b0);
        chk("w_gnt_clear", gnt, 4'b0);
        chk("w_start_count", starts - s0, 1);
        chk("w_done_count", dones - d0, 1);

        // Stray m_done while idle must be ignored
        d0 = dones;
        m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'h99;
        step();
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        step();
        chk("idle_mdone_err", err, 1'b0);
        chk("idle_mdone_rdata", rdata, 8'h00);
        chk("idle_mdone_done", dones - d0, 0);

        // Round-robin with all requesters held, starting from reset priority
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) req_addr[7*i +: 7] = 7'h10 + 7'(i);
        req_rw = 4'b0000;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            eg = 4'b0001 << (i % 4);
            step();
            chk($sformatf("rr%0d_gnt", i), gnt, eg);
            step();
            chk($sformatf("rr%0d_start", i), m_start, 1'b1);
            chk($sformatf("rr%0d_maddr", i), m_addr, 7'h10 + 7'(i % 4));
            m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'h50 + 8'(i);
            step();
            m_done = 1'b0;
            if (i == 4) req = 4'b0;
            step();
            chk($sformatf("rr%0d_done", i), done, eg);
            chk($sformatf("rr%0d_rdata", i), rdata, 8'h50 + 8'(i));
            chk($sformatf("rr%0d_err", i), err, 1'b0);
        end
        step();
        chk("rr_gnt_clear", gnt, 4'b0);

        // Read from requester 2 with NACK
        req_rw[2] = 1'b0; req_addr[20:14] = 7'h22; req = 4'b0100;
        step();
        chk("nack_gnt", gnt, 4'b0100);
        req = 4'b0;
        step();
        chk("nack_start", m_start, 1'b1);
        chk("nack_mrw", m_rw, 1'b0);
        chk("nack_maddr", m_addr, 7'h22);
        steps(5);
        m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'h3C;
        step();
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        step();
        chk("nack_done", done, 4'b0100);
        chk("nack_err", err, 1'b1);
        chk("nack_rdata", rdata, 8'h3C);
        step();
        chk("nack_done_pulse", done, 4'b0);
        chk("nack_err_hold", err, 1'b1);
        chk("nack_rdata_hold", rdata, 8'h3C);

        // Busy hold on requester 3
        m_busy = 1'b1;
        req_rw[3] = 1'b1; req_wdata[31:24] = 8'h5A; req = 4'b1000;
        s0 = starts;
        step();
        chk("busy_gnt", gnt, 4'b1000);
        req = 4'b0;
        steps(20);
        chk("busy_no_start", starts - s0, 0);
        chk("busy_mstart_low", m_start, 1'b0);
        m_busy = 1'b0;
        step();
        chk("busy_start", m_start, 1'b1);
        chk("busy_mwdata", m_wdata, 8'h5A);
        step();
        chk("busy_start_pulse", m_start, 1'b0);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        step();
        chk("busy_done", done, 4'b1000);
        chk("busy_err", err, 1'b0);
        chk("busy_start_count", starts - s0, 1);
        step();

        // Timeout on requester 0 read
        req_rw[0] = 1'b0; req = 4'b0001;
        step();
        chk("to_gnt", gnt, 4'b0001);
        req = 4'b0;
        step();
        chk("to_start", m_start, 1'b1);
        n = 0;
        while (done == 4'b0 && n < T + 100) begin
            step();
            n++;
        end
        chk("to_window", (n >= T - 1 && n <= T + 1), 1'b1);
        chk("to_done", done, 4'b0001);
        chk("to_err", err, 1'b1);
        chk("to_rdata", rdata, 8'h00);
        step();

        // Reset in the middle of WAIT, then a stray completion
        req_rw[1] = 1'b0; req = 4'b0010;
        step();
        chk("rw_gnt", gnt, 4'b0010);
        req = 4'b0;
        step();
        chk("rw_start", m_start, 1'b1);
        steps(10);
        d0 = dones; s0 = starts;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rw_gnt_rst", gnt, 4'b0);
        chk("rw_err_rst", err, 1'b0);
        m_done = 1'b1; m_rdata = 8'hEE;
        step();
        m_done = 1'b0; m_rdata = 8'h00;
        steps(3);
        chk("rw_no_done", dones - d0, 0);
        chk("rw_no_start", starts - s0, 0);
        chk("rw_gnt_idle", gnt, 4'b0);
        chk("rw_rdata", rdata, 8'h00);
        req = 4'b1111;
        step();
        chk("rw_next_gnt", gnt, 4'b0001);
        req = 4'b0;
        steps(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters; only 4 is required.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of WAIT cycles before a transaction is aborted.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low (rst=0 resets).
REQ-005 req  in  4  request, bit i is requester i.
REQ-006 req_rw  in  4  direction per requester: 1=write, 0=read.
REQ-007 req_addr  in  28  7-bit slave address; requester i at [7i+6:7i].
REQ-008 req_wdata  in  32  write byte; requester i at [8i+7:8i].
REQ-009 gnt  out  4  one-hot grant; at most one bit set.
REQ-010 done  out  4  one-cycle completion pulse to the granted requester.
REQ-011 rdata  out  8  read byte; valid in the done cycle and held afterwards.
REQ-012 err  out  1  NACK or timeout flag; valid in the done cycle and held afterwards.
REQ-013 m_start  out  1  one-cycle command pulse to the I2C master.
REQ-014 m_rw, m_addr[6:0], m_wdata[7:0]  out  command fields; stable from m_start until the cycle after done.
REQ-015 m_busy  in  1  the master is mid-transfer.
REQ-016 m_done  in  1  one-cycle pulse when the master finishes, including the stop condition.
REQ-017 m_nack  in  1  address or data NACK; valid with m_done.
REQ-018 m_rdata  in  8  received byte; valid with m_done.

Function
REQ-019 The FSM SHALL have exactly four states, IDLE, ISSUE, WAIT and RESP, with a registered state and a 2-bit registered last-grant index.
REQ-020 In IDLE with req!=0, the block SHALL select the first set bit searching round-robin from last+1 mod 4, latch that requester's rw/addr/wdata, set gnt one-hot, and enter ISSUE on the next edge.
REQ-021 In IDLE with req==0, the block SHALL keep outputs unchanged except done=0 and gnt=0.
REQ-022 Latency: when req is sampled in IDLE at edge N, gnt SHALL be high after N+1, and m_start SHALL be high for exactly the cycle following edge N+1 if m_busy=0.
REQ-023 In ISSUE with m_busy=1, the block SHALL hold m_start=0 and remain in ISSUE; once m_busy=0 it SHALL pulse m_start for one cycle and enter WAIT.
REQ-024 In WAIT, on m_done=1 the block SHALL capture rdata=m_rdata for a read (rdata=8'h00 for a write) and err=m_nack, then enter RESP.
REQ-025 In WAIT, a 10-bit-minimum cycle counter, cleared on WAIT entry, SHALL abort when it reaches TIMEOUT-1 with no m_done: rdata=8'h00, err=1, enter RESP.
REQ-026 When m_done and timeout coincide, m_done SHALL win (err=m_nack).
REQ-027 In RESP, done[idx] SHALL pulse for one cycle, last SHALL be set to idx, and the FSM SHALL return to IDLE; gnt SHALL be cleared in the following cycle.
REQ-028 If the granted requester drops req before done, the transaction SHALL still complete and the done pulse SHALL still be issued.
REQ-029 A requester still holding req after done SHALL re-enter arbitration at the lowest round-robin priority.
REQ-030 m_done outside WAIT SHALL be ignored.
REQ-031 req changes outside IDLE SHALL be ignored.
REQ-032 Back-to-back transactions SHALL be spaced by at least one IDLE cycle.

Reset
REQ-033 With rst=0 at an edge, the block SHALL enter IDLE with gnt=0, done=0, m_start=0, m_rw=0, m_addr=0, m_wdata=0, rdata=8'h00, err=0, counter=0, and last=3 (so requester 0 has first priority).
REQ-034 Reset mid-transaction SHALL abort with no done pulse; any subsequent m_done SHALL be ignored.

Verification
REQ-035 Single write: req=4'b0010, addr1=7'h77, wdata1=8'hA5, rw=1, m_done after 40 cycles with m_nack=0 -> one m_start with m_addr=7'h77, m_wdata=8'hA5, m_rw=1; done=4'b0010; err=0; rdata=8'h00.
REQ-036 Round-robin: req=4'b1111 held, every transaction completes -> grant order 0,1,2,3,0; each done is on the matching bit.
REQ-037 Read with NACK: requester 2 read, m_done with m_nack=1 and m_rdata=8'h3C -> done=4'b0100, err=1, rdata=8'h3C.
REQ-038 Timeout: m_done never asserted -> done pulse exactly TIMEOUT cycles after WAIT entry (within 1 cycle), err=1, rdata=8'h00.
REQ-039 Busy hold: m_busy=1 for 20 cycles after grant -> m_start stays low, then pulses exactly once the cycle after m_busy falls.
REQ-040 Reset mid-WAIT: rst=0 for one cycle, then a stray m_done -> gnt=0, no done pulse, state IDLE, next grant goes to requester 0.
